// File: rtl/bcd_sevenseg_mux.sv
// Three-digit multiplexed BCD seven-segment driver.
// A prescaler divides the clock into digit slots; a scan index walks the
// hundreds, tens and units digits in turn. Inputs are captured into shadow
// registers once per frame so a display never mixes two input values.
// Every output is registered and reflects the scan state of the previous cycle.
module bcd_sevenseg_mux #(
    parameter int DIV   = 50000,
    parameter int GUARD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [2:0] dp,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic [3:0] an,
    output logic       frame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] PCNT_ONE = PW'(1);
    localparam logic [PW-1:0] GUARD_V  = PW'(GUARD);

    // Scan index states: one per displayed digit
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Active-low gfedcba pattern for one BCD digit; non-BCD codes show a dash
    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    sh2_q, sh2_d;
    logic [3:0]    sh1_q, sh1_d;
    logic [3:0]    sh0_q, sh0_d;
    logic [2:0]    shdp_q, shdp_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_n_q, dp_n_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          snap;

    // Prescaler, scan index advance and once-per-frame input snapshot
    always_comb begin
        tick    = (pcnt_q == PCNT_MAX);
        snap    = tick && (idx_q == S2);
        pcnt_d  = tick ? '0 : (pcnt_q + PCNT_ONE);
        idx_d   = idx_q;
        if (tick) begin
            case (idx_q)
                S0:      idx_d = S1;
                S1:      idx_d = S2;
                default: idx_d = S0;
            endcase
        end
        sh2_d   = sh2_q;
        sh1_d   = sh1_q;
        sh0_d   = sh0_q;
        shdp_d  = shdp_q;
        if (snap) begin
            sh2_d  = d2;
            sh1_d  = d1;
            sh0_d  = d0;
            shdp_d = dp;
        end
        frame_d = snap;
    end

    // Output pattern for the current slot: guard interval, blanking, then digit
    always_comb begin
        logic [3:0] digit;
        logic       dp_sel;
        logic       guard;
        logic       blank;

        case (idx_q)
            S0:      begin digit = sh0_q; dp_sel = shdp_q[0]; end
            S1:      begin digit = sh1_q; dp_sel = shdp_q[1]; end
            default: begin digit = sh2_q; dp_sel = shdp_q[2]; end
        endcase

        guard = (pcnt_q < GUARD_V);
        // Leading-zero blanking uses the live enable but the shadowed digits
        blank = blank_lz &&
                (((idx_q == S2) && (sh2_q == 4'd0)) ||
                 ((idx_q == S1) && (sh2_q == 4'd0) && (sh1_q == 4'd0)));

        seg_d  = SEG_OFF;
        an_d   = AN_OFF;
        dp_n_d = 1'b1;
        if (!guard && !blank) begin
            seg_d  = seg7_decode(digit);
            dp_n_d = ~dp_sel;
            case (idx_q)
                S0:      an_d = 4'b1110;
                S1:      an_d = 4'b1101;
                default: an_d = 4'b1011;
            endcase
        end
    end

    // State and output registers; reset overrides the prescaler tick
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= '0;
            idx_q   <= S0;
            sh2_q   <= 4'd0;
            sh1_q   <= 4'd0;
            sh0_q   <= 4'd0;
            shdp_q  <= 3'd0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            dp_n_q  <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            sh2_q   <= sh2_d;
            sh1_q   <= sh1_d;
            sh0_q   <= sh0_d;
            shdp_q  <= shdp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_n_q  <= dp_n_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp_n  = dp_n_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_sevenseg_mux.sv
// Bench for bcd_sevenseg_mux with DIV=8, GUARD=2.
// A timeline model (cycles since reset release) predicts each cycle's
// {frame, an, dp_n, seg}; predictions are queued as each edge is driven
// and popped when the DUT output for that edge is sampled.
module tb_bcd_sevenseg_mux;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRM   = 3 * DIV;

    logic       clk;
    logic       rst;
    logic [3:0] d2, d1, d0;
    logic [2:0] dp;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp_n;
    logic [3:0] an;
    logic       frame;

    bcd_sevenseg_mux #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk      (clk),
        .rst      (rst),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0),
        .dp       (dp),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp_n     (dp_n),
        .an       (an),
        .frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] exp_q[$];

    // Model state: cycles since reset release and the captured inputs
    int          m_t = 0;
    logic [3:0]  m_sh2 = 4'd0, m_sh1 = 4'd0, m_sh0 = 4'd0;
    logic [2:0]  m_shdp = 3'd0;

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [12:0] model_out(input int tt, input logic blz);
        int         pos;
        int         slot;
        logic [3:0] dig;
        logic [3:0] a;
        logic [6:0] s;
        logic       dn;
        logic       fr;
        logic       blank;
        pos  = tt % DIV;
        slot = (tt / DIV) % 3;
        fr   = ((tt % FRM) == FRM - 1);
        a    = 4'hF;
        s    = 7'h7F;
        dn   = 1'b1;
        case (slot)
            0:       dig = m_sh0;
            1:       dig = m_sh1;
            default: dig = m_sh2;
        endcase
        blank = blz && ((slot == 2 && m_sh2 == 4'd0) ||
                        (slot == 1 && m_sh2 == 4'd0 && m_sh1 == 4'd0));
        if (pos >= GUARD && !blank) begin
            a[slot] = 1'b0;
            s       = seg_ref(dig);
            dn      = ~m_shdp[slot];
        end
        return {fr, a, dn, s};
    endfunction

    // Queue the prediction for the coming edge, update the model, clock once
    task automatic advance();
        logic [12:0] e;
        if (rst) e = {1'b0, 4'hF, 1'b1, 7'h7F};
        else     e = model_out(m_t, blank_lz);
        exp_q.push_back(e);
        if (rst) begin
            m_t    = 0;
            m_sh2  = 4'd0;
            m_sh1  = 4'd0;
            m_sh0  = 4'd0;
            m_shdp = 3'd0;
        end else begin
            if ((m_t % FRM) == FRM - 1) begin
                m_sh2  = d2;
                m_sh1  = d1;
                m_sh0  = d0;
                m_shdp = dp;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst = 1'b1; d2 = 4'd2; d1 = 4'd5; d0 = 4'd5; dp = 3'b000; blank_lz = 1'b0;
        repeat (3) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL reset: got %h expected %h", {frame, an, dp_n, seg}, e);
            end
        end
        n_checks++;
        if ({an, seg, dp_n, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got an=%b seg=%h dp_n=%b frame=%b, expected 1111 7f 1 0",
                     an, seg, dp_n, frame);
        end
        rst = 1'b0;
    endtask

    // 2,5,5 scan after shadow 000; frames must be 24 cycles apart
    task automatic test_scan_pattern();
        logic [12:0] e;
        int last_fr = -1;
        for (int k = 0; k < 3 * FRM; k++) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL scan t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
            if (frame === 1'b1) begin
                if (last_fr >= 0) begin
                    n_checks++;
                    if (k - last_fr != FRM) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d expected %0d", k - last_fr, FRM);
                    end
                end
                last_fr = k;
            end
        end
    endtask

    task automatic test_blanking();
        logic [12:0] e;
        blank_lz = 1'b1; d2 = 4'd0; d1 = 4'd0; d0 = 4'd7;
        for (int k = 0; k < 3 * FRM; k++) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL blank_007 t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
            if (an == 4'b1110) begin
                n_checks++;
                if (seg !== 7'h78 && m_sh0 == 4'd7) begin
                    n_fail++;
                    $display("FAIL blank_d0_seg: got %h expected 78", seg);
                end
            end
        end
        d0 = 4'd0;
        for (int k = 0; k < 2 * FRM; k++) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL blank_000 t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_dash_dp();
        logic [12:0] e;
        d2 = 4'd1; d1 = 4'hC; d0 = 4'd2; dp = 3'b010;
        for (int k = 0; k < 2 * FRM; k++) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL dash_dp t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
        end
        dp = 3'b000;
    endtask

    // d0 changes 3 -> 8 in the S1 slot; display must hold 3 until next snapshot
    task automatic test_no_tearing();
        logic [12:0] e;
        int guard_cnt = 0;
        d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
        for (int k = 0; k < FRM; k++) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL tear_pre t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
        end
        while ((m_t % FRM) != DIV + 2 && guard_cnt < FRM) begin
            advance();
            guard_cnt++;
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL tear_align t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
        end
        d0 = 4'd8;
        for (int k = 0; k < 2 * FRM; k++) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL tear_post t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
        end
    endtask

    // One-cycle reset in the middle of S2, then a full restart
    task automatic test_mid_reset();
        logic [12:0] e;
        int guard_cnt = 0;
        int first_fr  = -1;
        while ((m_t % FRM) != 2 * DIV + 4 && guard_cnt < FRM) begin
            advance();
            guard_cnt++;
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL rst_align t=%0d: got %h expected %h", m_t, {frame, an, dp_n, seg}, e);
            end
        end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({frame, an, dp_n, seg} !== e || {an, seg, frame} !== {4'hF, 7'h7F, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: got an=%b seg=%h frame=%b, expected 1111 7f 0", an, seg, frame);
        end
        for (int k = 1; k <= FRM + 16; k++) begin
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({frame, an, dp_n, seg} !== e) begin
                n_fail++;
                $display("FAIL rst_restart k=%0d: got %h expected %h", k, {frame, an, dp_n, seg}, e);
            end
            if (frame === 1'b1 && first_fr < 0) first_fr = k;
        end
        n_checks++;
        if (first_fr != FRM) begin
            n_fail++;
            $display("FAIL rst_first_frame: got cycle %0d expected %0d", first_fr, FRM);
        end
    endtask

    initial begin
        test_reset();
        test_scan_pattern();
        test_blanking();
        test_dash_dp();
        test_no_tearing();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
